// File: rtl/map_ss_seq.sv
// Save-state sequencer: walks the mapper save-state slots and copies them to a buffer RAM (save) or back (load).
// Optional `MAP_SS_SUM_EN adds an 8-bit wrapping checksum output ss_sum.
module map_ss_seq #(
   parameter int SS_LEN  = 128,
   parameter int M2_SYNC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m2,
   input  logic       save_req,
   input  logic       load_req,
   output logic       busy,
   output logic       done,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdat,
   output logic       mem_we,
   input  logic [7:0] mem_rdat
`ifdef MAP_SS_SUM_EN
   ,
   output logic [7:0] ss_sum
`endif
);

   localparam logic [7:0] LAST_IDX = 8'(SS_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      S_RD,
      S_WR,
      L_RD,
      L_WT,
      L_DRV,
      L_HOLD,
      FIN
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           idx_q, idx_d;
   logic                 settle_q, settle_d;
   logic [7:0]           wdat_q, wdat_d;
   logic [M2_SYNC-1:0]   m2_sync_q, m2_sync_d;
   logic                 m2_prev_q, m2_prev_d;
   logic                 m2_fall;
   logic                 start;

   // m2 is asynchronous to clk; the fall is detected on the synchronized copy.
   always_comb begin
      m2_sync_d    = m2_sync_q;
      m2_sync_d[0] = m2;
      for (int i = 1; i < M2_SYNC; i++) begin
         m2_sync_d[i] = m2_sync_q[i-1];
      end
      m2_prev_d = m2_sync_q[M2_SYNC-1];
      m2_fall   = m2_prev_q & ~m2_sync_q[M2_SYNC-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_sync_q <= '0;
         m2_prev_q <= 1'b0;
      end else begin
         m2_sync_q <= m2_sync_d;
         m2_prev_q <= m2_prev_d;
      end
   end

   assign start = (state_q == IDLE) && (save_req || load_req);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = 1'b0;
      wdat_d   = wdat_q;
      busy     = 1'b0;
      done     = 1'b0;
      ss_act   = 1'b1;
      ss_we    = 1'b0;
      mem_we   = 1'b0;
      mem_wdat = 8'h00;
      case (state_q)
         IDLE: begin
            ss_act = 1'b0;
            if (save_req) begin
               state_d = S_RD;
               idx_d   = 8'h00;
            end else if (load_req) begin
               state_d = L_RD;
               idx_d   = 8'h00;
            end
         end
         S_RD: begin
            // Two cycles for the mapper readback mux to settle.
            busy     = 1'b1;
            settle_d = ~settle_q;
            if (settle_q) begin
               state_d = S_WR;
            end
         end
         S_WR: begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            mem_wdat = ss_rdat;
            if (idx_q == LAST_IDX) begin
               state_d = FIN;
            end else begin
               idx_d   = idx_q + 8'h01;
               state_d = S_RD;
            end
         end
         L_RD: begin
            busy    = 1'b1;
            state_d = L_WT;
         end
         L_WT: begin
            busy    = 1'b1;
            wdat_d  = mem_rdat;
            state_d = L_DRV;
         end
         L_DRV: begin
            busy  = 1'b1;
            ss_we = 1'b1;
            if (m2_fall) begin
               state_d = L_HOLD;
            end
         end
         L_HOLD: begin
            // Keep the write stable past the mapper's latching edge.
            busy  = 1'b1;
            ss_we = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = FIN;
            end else begin
               idx_d   = idx_q + 8'h01;
               state_d = L_RD;
            end
         end
         FIN: begin
            done    = 1'b1;
            idx_d   = 8'h00;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ss_addr  = idx_q;
   assign ss_wdat  = wdat_q;
   assign mem_addr = idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= 8'h00;
         settle_q <= 1'b0;
         wdat_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         wdat_q   <= wdat_d;
      end
   end

`ifdef MAP_SS_SUM_EN
   logic [7:0] sum_q, sum_d;

   // Sums exactly the bytes that cross into the buffer or onto ss_wdat.
   always_comb begin
      sum_d = sum_q;
      if (start) begin
         sum_d = 8'h00;
      end else if (state_q == S_WR) begin
         sum_d = sum_q + ss_rdat;
      end else if (state_q == L_WT) begin
         sum_d = sum_q + mem_rdat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign ss_sum = sum_q;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: SS_LEN=4 and SS_LEN=256 instances against a slot-level model of mapper, RAM and m2.
module tb_map_ss_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, m2;
   logic save4, load4, busy4, done4, act4, we4, mwe4;
   logic [7:0] addr4, wdat4, rdat4, maddr4, mwdat4, mrdat4;
   logic save_b, load_b, busy_b, done_b, act_b, we_b, mwe_b;
   logic [7:0] addr_b, wdat_b, rdat_b, maddr_b, mwdat_b, mrdat_b;
`ifdef MAP_SS_SUM_EN
   logic [7:0] sum4, sum_b;
`endif

   map_ss_seq #(.SS_LEN(4), .M2_SYNC(2)) dut4 (
      .clk(clk), .rst(rst), .m2(m2), .save_req(save4), .load_req(load4),
      .busy(busy4), .done(done4), .ss_act(act4), .ss_we(we4), .ss_addr(addr4),
      .ss_wdat(wdat4), .ss_rdat(rdat4), .mem_addr(maddr4), .mem_wdat(mwdat4),
      .mem_we(mwe4), .mem_rdat(mrdat4)
`ifdef MAP_SS_SUM_EN
      , .ss_sum(sum4)
`endif
   );

   map_ss_seq #(.SS_LEN(256), .M2_SYNC(2)) dut_b (
      .clk(clk), .rst(rst), .m2(m2), .save_req(save_b), .load_req(load_b),
      .busy(busy_b), .done(done_b), .ss_act(act_b), .ss_we(we_b), .ss_addr(addr_b),
      .ss_wdat(wdat_b), .ss_rdat(rdat_b), .mem_addr(maddr_b), .mem_wdat(mwdat_b),
      .mem_we(mwe_b), .mem_rdat(mrdat_b)
`ifdef MAP_SS_SUM_EN
      , .ss_sum(sum_b)
`endif
   );

   // Mapper register file and buffer RAM contents as seen by the sequencer.
   logic [7:0] map4 [4];
   logic [7:0] ram4 [4];
   logic [7:0] map_b [256];

   assign rdat4   = (addr4 < 8'd4) ? map4[addr4[1:0]] : 8'hEE;
   assign rdat_b  = map_b[addr_b];
   assign mrdat_b = 8'h00;
   assign load_b  = 1'b0;
   always @(posedge clk) mrdat4 <= (maddr4 < 8'd4) ? ram4[maddr4[1:0]] : 8'hEE;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // m2: period 6 clk, edges 2 ns after the clk rising edge; held high when stalled.
   logic m2_run = 1'b1;
   initial begin
      int ph;
      ph = 0;
      m2 = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (!m2_run) begin
            m2 = 1'b1;
            ph = 0;
         end else begin
            ph = ph + 1;
            if (ph == 3) begin
               m2 = ~m2;
               ph = 0;
            end
         end
      end
   end

   // Observation logs: buffer writes, mapper writes (latched on m2 fall), m2 falls per ss_we window.
   int mw4_a[$], mw4_d[$], mw4_c[$];
   int mwb_a[$], mwb_d[$], mwb_c[$];
   int lw_a[$], lw_d[$], win_q[$];
   int done_n4 = 0, done_nb = 0, win_cnt = 0;
   logic m2_prev = 1'b1, we_prev = 1'b0;

   always @(negedge clk) begin
      if (mwe4) begin
         mw4_a.push_back(int'(maddr4)); mw4_d.push_back(int'(mwdat4)); mw4_c.push_back(cyc);
      end
      if (mwe_b) begin
         mwb_a.push_back(int'(maddr_b)); mwb_d.push_back(int'(mwdat_b)); mwb_c.push_back(cyc);
      end
      if (done4) done_n4 <= done_n4 + 1;
      if (done_b) done_nb <= done_nb + 1;
      if (we4 && m2_prev && !m2) begin
         lw_a.push_back(int'(addr4)); lw_d.push_back(int'(wdat4));
      end
      if (we_prev && !we4) begin
         if (!rst) win_q.push_back(win_cnt);
         win_cnt <= 0;
      end else if (we4 && m2_prev && !m2) begin
         win_cnt <= win_cnt + 1;
      end
      m2_prev <= m2;
      we_prev <= we4;
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done4(input int budget, output int dc);
      dc = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done4) begin
            dc = cyc;
            break;
         end
      end
      chk("done4_seen", done4, 1'b1);
   endtask

   task automatic sync_m2_fall();
      logic p;
      bit found;
      p = m2;
      found = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (p && !m2) begin
            found = 1;
            break;
         end
         p = m2;
      end
      chk("m2_fall_seen", found, 1'b1);
   endtask

   task automatic save4_run(input bit both, input bit stray);
      int n0, d0, l0, acc, dc, s;
      n0 = mw4_a.size(); d0 = done_n4; l0 = lw_a.size();
      @(negedge clk);
      save4 = 1'b1; load4 = both;
      @(posedge clk); #1;
      acc = cyc; save4 = 1'b0; load4 = 1'b0;
      chk("save_busy", busy4, 1'b1);
      chk("save_act", act4, 1'b1);
      chk("save_addr0", addr4, 8'h00);
      if (stray) begin
         repeat (4) @(negedge clk);
         load4 = 1'b1; save4 = 1'b1;
         @(negedge clk);
         load4 = 1'b0; save4 = 1'b0;
      end
      wait_done4(60, dc);
      chk("save_done_cyc", dc, acc + 12);
      chk("save_busy_at_done", busy4, 1'b0);
      repeat (2) @(negedge clk);
      chk("save_nwr", mw4_a.size() - n0, 4);
      s = 0;
      for (int i = 0; i < 4; i++) begin
         s += int'(map4[i]);
         if (n0 + i < mw4_a.size()) begin
            chk("save_addr", mw4_a[n0+i], i);
            chk("save_data", mw4_d[n0+i], int'(map4[i]));
            chk("save_wr_cyc", mw4_c[n0+i], acc + 3*i + 2);
         end
      end
      chk("save_ndone", done_n4 - d0, 1);
      chk("save_no_map_wr", lw_a.size() - l0, 0);
      chk("save_idle_act", act4, 1'b0);
`ifdef MAP_SS_SUM_EN
      chk("save_sum", sum4, s % 256);
`endif
   endtask

   task automatic load4_run();
      int n0, d0, l0, w0, dc, s;
      n0 = mw4_a.size(); d0 = done_n4; l0 = lw_a.size(); w0 = win_q.size();
      sync_m2_fall();
      load4 = 1'b1;
      @(posedge clk); #1;
      load4 = 1'b0;
      chk("load_busy", busy4, 1'b1);
      chk("load_addr0", addr4, 8'h00);
      wait_done4(60, dc);
      chk("load_busy_at_done", busy4, 1'b0);
      repeat (2) @(negedge clk);
      chk("load_nwr", lw_a.size() - l0, 4);
      s = 0;
      for (int i = 0; i < 4; i++) begin
         s += int'(ram4[i]);
         if (l0 + i < lw_a.size()) begin
            chk("load_addr", lw_a[l0+i], i);
            chk("load_data", lw_d[l0+i], int'(ram4[i]));
         end
         if (w0 + i < win_q.size()) chk("load_we_window_falls", win_q[w0+i], 1);
      end
      chk("load_nwindows", win_q.size() - w0, 4);
      chk("load_no_buf_wr", mw4_a.size() - n0, 0);
      chk("load_ndone", done_n4 - d0, 1);
`ifdef MAP_SS_SUM_EN
      chk("load_sum", sum4, s % 256);
`endif
   endtask

   initial begin
      int d0, n0, acc, dc, errs;
      bit found;
      rst = 1'b1; save4 = 1'b0; load4 = 1'b0; save_b = 1'b0;
      foreach (map_b[i]) map_b[i] = 8'($urandom);
      map4[0] = 8'h02; map4[1] = 8'h15; map4[2] = 8'h05; map4[3] = 8'hFF;
      ram4[0] = 8'h03; ram4[1] = 8'h7F; ram4[2] = 8'h06; ram4[3] = 8'h00;

      repeat (3) @(negedge clk);
      chk("reset_ctl", {busy4, done4, act4, we4, mwe4}, 5'b0);
      chk("reset_addr", {addr4, maddr4}, 16'h0);
      chk("reset_dat", {wdat4, mwdat4}, 16'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      save4_run(0, 0);
      load4_run();
      save4_run(1, 0);

      for (int r = 0; r < 3; r++) begin
         foreach (map4[i]) map4[i] = 8'($urandom);
         save4_run(0, 1);
         foreach (ram4[i]) ram4[i] = 8'($urandom);
         load4_run();
      end

      // Reset in the middle of a load, while driving slot 2.
      d0 = done_n4;
      sync_m2_fall();
      load4 = 1'b1;
      @(posedge clk); #1;
      load4 = 1'b0;
      found = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (we4 && addr4 == 8'd2) begin
            found = 1;
            break;
         end
      end
      chk("rst_reach_slot2", found, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_ctl", {busy4, done4, act4, we4, mwe4}, 5'b0);
      chk("rst_mid_addr", {addr4, maddr4}, 16'h0);
      chk("rst_mid_dat", {wdat4, mwdat4}, 16'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_done", done_n4 - d0, 0);
      foreach (ram4[i]) ram4[i] = 8'($urandom);
      load4_run();

      // Stalled m2: the pass must wait in slot 0 indefinitely.
      m2_run = 1'b0;
      d0 = done_n4;
      repeat (8) @(negedge clk);
      load4 = 1'b1;
      @(negedge clk);
      load4 = 1'b0;
      repeat (80) @(negedge clk);
      chk("stall_busy", busy4, 1'b1);
      chk("stall_we", we4, 1'b1);
      chk("stall_addr", addr4, 8'h00);
      chk("stall_no_done", done_n4 - d0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m2_run = 1'b1;
      repeat (2) @(negedge clk);

      // Full 256-slot save: idx must reach 255 without wrapping.
      n0 = mwb_a.size(); d0 = done_nb;
      @(negedge clk);
      save_b = 1'b1;
      @(posedge clk); #1;
      acc = cyc; save_b = 1'b0;
      chk("big_busy", {busy_b, act_b}, 2'b11);
      dc = -1;
      for (int k = 0; k < 900; k++) begin
         @(negedge clk);
         if (done_b) begin
            dc = cyc;
            break;
         end
      end
      chk("big_done_seen", done_b, 1'b1);
      chk("big_done_cyc", dc, acc + 768);
      repeat (2) @(negedge clk);
      chk("big_nwr", mwb_a.size() - n0, 256);
      chk("big_ndone", done_nb - d0, 1);
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         if (n0 + i < mwb_a.size()) begin
            if (mwb_a[n0+i] != i || mwb_d[n0+i] != int'(map_b[i]) || mwb_c[n0+i] != acc + 3*i + 2)
               errs++;
         end
      end
      chk("big_slot_errors", errs, 0);
      if (mwb_a.size() > n0) chk("big_last_addr", mwb_a[mwb_a.size()-1], 255);
      chk("big_no_map_wr", {we_b, wdat_b}, 9'h0);
`ifdef MAP_SS_SUM_EN
      errs = 0;
      foreach (map_b[i]) errs += int'(map_b[i]);
      chk("big_sum", sum_b, errs % 256);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/map_ss_seq.md
MAP_SS_SEQ -- requirements
Module: map_ss_seq

Interface
REQ-001 SHALL have parameter SS_LEN, default 128, number of save-state register slots walked (ss_addr 0..SS_LEN-1, 1..256).
REQ-002 SHALL have parameter M2_SYNC, default 2, synchronizer depth on m2.
REQ-003 SHALL have port clk  input  1  system clock; sole clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port m2  input  1  raw CPU M2; the mapper latches save-state writes on its falling edge.
REQ-006 SHALL have port save_req  input  1  one-cycle pulse, start a save pass.
REQ-007 SHALL have port load_req  input  1  one-cycle pulse, start a restore pass.
REQ-008 SHALL have port busy  output  1  high from accepted request until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of a pass.
REQ-010 SHALL have ports ss_act, ss_we (output, 1 each), ss_addr (output, 8) and ss_wdat (output, 8), which form the mapper save-state control bus.
REQ-011 SHALL have port ss_rdat  input  8  mapper readback for the current ss_addr.
REQ-012 SHALL have ports mem_addr (output, 8), mem_wdat (output, 8), mem_we (output, 1) and mem_rdat (input, 8), which form the buffer RAM port; read latency is 1 clk.

Function
REQ-013 SHALL use the states IDLE, S_RD, S_WR, L_RD, L_WT, L_DRV, L_HOLD and FIN.
REQ-014 SHALL, in IDLE, accept save_req by entering S_RD with idx=0; if only load_req is asserted, it SHALL enter L_RD with idx=0.
REQ-015 SHALL, when save_req and load_req are asserted in the same cycle in IDLE, give priority to save.
REQ-016 SHALL ignore both requests while busy.
REQ-017 SHALL hold ss_act=1 in every state other than IDLE; ss_addr SHALL equal idx.
REQ-018 SHALL, in S_RD, wait exactly 2 clk for ss_rdat to settle, then enter S_WR.
REQ-019 SHALL, in S_WR, assert mem_we for 1 clk with mem_addr=idx and mem_wdat=ss_rdat.
REQ-020 SHALL, after S_WR, enter FIN if idx==SS_LEN-1; otherwise it SHALL increment idx and return to S_RD.
REQ-021 SHALL, in L_RD, drive mem_addr=idx for 1 clk; L_WT SHALL then capture mem_rdat into ss_wdat.
REQ-022 SHALL, in L_DRV, assert ss_we and hold it until a synchronized m2 falling edge is detected, then enter L_HOLD.
REQ-023 SHALL, in L_HOLD, keep ss_we, ss_addr and ss_wdat stable for 1 more clk, then enter FIN if idx==SS_LEN-1; otherwise it SHALL increment idx and return to L_RD.
REQ-024 SHALL detect the m2 falling edge after an M2_SYNC-stage synchronizer; only edges arriving while in L_DRV count.
REQ-025 SHALL make idx 8 bits wide; with SS_LEN=256 the final slot is 255, and idx SHALL NOT wrap before FIN.
REQ-026 SHALL, in FIN, pulse done for 1 clk, drop ss_act, and return to IDLE; busy SHALL fall in the same cycle done rises.
REQ-027 SHALL drive ss_we=0 in all states except L_DRV and L_HOLD, and mem_we=0 except in S_WR.

Reset
REQ-028 SHALL, on rst assertion, immediately force the state to IDLE and drive busy=0, done=0, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, mem_addr=0, mem_wdat=0, mem_we=0 and idx=0, and clear the synchronizer.
REQ-029 SHALL abandon a pass when rst is asserted mid-pass, with no done pulse; the partial buffer contents are undefined.

Configuration
REQ-030 SHALL, with MAP_SS_SUM_EN defined, add output ss_sum (8 bits): cleared on pass start, and accumulating the 8-bit wrapping sum of every byte written to the buffer (save) or to ss_wdat (load); it SHALL be valid while done is high and held until the next pass.
REQ-031 SHALL, without MAP_SS_SUM_EN, have no ss_sum port and no adder logic.

Verification
REQ-032 SHALL cover a save pass: with SS_LEN=4 and mapper model values {0x02,0x15,0x05,0xFF}, save_req results in buffer[0..3]={0x02,0x15,0x05,0xFF}, one done pulse, and ss_sum=0x1B with the macro on.
REQ-033 SHALL cover a load pass: with SS_LEN=4 and buffer {0x03,0x7F,0x06,0x00}, load_req with an m2 period of 6 clk results in the mapper model receiving 0x03@0, 0x7F@1, 0x06@2 and 0x00@3, each ss_we spanning exactly one m2 falling edge.
REQ-034 SHALL cover simultaneous requests: save_req=load_req=1 in one cycle results in a save pass only, with no mapper writes.
REQ-035 SHALL cover a mid-pass reset: rst asserted during L_DRV at idx=2 results in all outputs going to 0 in the same cycle, no done pulse, and a subsequent load_req restarting at ss_addr=0.
REQ-036 SHALL cover the boundary and the stalled-m2 case: with SS_LEN=256, a save covers ss_addr 0..255 with done after slot 255; with m2 held high during a load, the block stays in L_DRV at idx=0 with busy=1 indefinitely.
